// File: rtl/shift_sequencer_if.sv
// Command and shift-register drive bundle for shift_sequencer.
// The master side offers commands; the slave side sequences them onto sel/D/inp.
interface shift_sequencer_if #(
    parameter int unsigned CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [1:0]       cmd_data;
    logic             cmd_inp;
    logic [2:0]       sel;
    logic [1:0]       D;
    logic             inp;
    logic [1:0]       q_model;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_count,
        output cmd_data,
        output cmd_inp,
        input  cmd_ready,
        input  sel,
        input  D,
        input  inp,
        input  q_model,
        input  busy,
        input  done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_count,
        input  cmd_data,
        input  cmd_inp,
        output cmd_ready,
        output sel,
        output D,
        output inp,
        output q_model,
        output busy,
        output done
    );
endinterface

// File: rtl/shift_sequencer.sv
// Repeats one operation on a negedge-clocked 2-bit multi-function shift register
// count+1 times, keeping a shadow of the register contents in q_model.
module shift_sequencer #(
    parameter int unsigned CNT_W = 4
) (
    input logic               clk,
    input logic               rst,
    shift_sequencer_if.slave  bus
);

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    localparam logic [2:0] SelHold = 3'b001;

    state_e           r_state;
    state_e           w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;

    logic [2:0]       r_op;
    logic [1:0]       r_data;
    logic             r_inp;

    logic [2:0]       r_sel;
    logic [2:0]       w_sel_d;
    logic [1:0]       r_d;
    logic [1:0]       w_d_d;
    logic             r_sin;
    logic             w_sin_d;
    logic [1:0]       r_q;
    logic [1:0]       w_q_d;
    logic             r_done;
    logic             w_done_d;

    logic             w_accept;

    // Contents of the shift register after one clock with the given select.
    function automatic logic [1:0] next_q(
        input logic [2:0] op,
        input logic [1:0] q,
        input logic [1:0] data,
        input logic       sin
    );
        logic [1:0] res;
        case (op)
            3'b000:  res = 2'b00;
            3'b001:  res = data;
            3'b010:  res = {1'b0, q[1]};
            3'b011:  res = {q[0], 1'b0};
            3'b100:  res = {q[1], q[1]};
            3'b101:  res = {sin, q[1]};
            default: res = {data[0], data[1]};
        endcase
        return res;
    endfunction

    assign w_accept = bus.cmd_valid && (r_state == StIdle);

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        // Idle hold: reload the register with its own value (it has no hold code).
        w_sel_d   = SelHold;
        w_d_d     = r_q;
        w_sin_d   = 1'b0;
        w_q_d     = r_q;
        w_done_d  = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_d = StRun;
                    w_cnt_d   = bus.cmd_count;
                end
            end
            StRun: begin
                w_sel_d = r_op;
                w_d_d   = r_data;
                w_sin_d = r_inp;
                w_q_d   = next_q(r_op, r_q, r_data, r_inp);
                if (r_cnt == '0) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                end else begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_op    <= 3'b000;
            r_data  <= 2'b00;
            r_inp   <= 1'b0;
            r_sel   <= 3'b000;
            r_d     <= 2'b00;
            r_sin   <= 1'b0;
            r_q     <= 2'b00;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_sel   <= w_sel_d;
            r_d     <= w_d_d;
            r_sin   <= w_sin_d;
            r_q     <= w_q_d;
            r_done  <= w_done_d;
            if (w_accept) begin
                r_op   <= bus.cmd_op;
                r_data <= bus.cmd_data;
                r_inp  <= bus.cmd_inp;
            end
        end
    end

    assign bus.cmd_ready = (r_state == StIdle) && !rst;
    assign bus.busy      = (r_state == StRun);
    assign bus.done      = r_done;
    assign bus.sel       = r_sel;
    assign bus.D         = r_d;
    assign bus.inp       = r_sin;
    assign bus.q_model   = r_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a negedge shift-register model that
// must track q_model every cycle.
module tb_shift_sequencer;

    localparam int unsigned CNT_W = 4;

    logic       clk;
    logic       rst;
    int         n_vec = 0;
    int         n_err = 0;
    logic       sync_en = 1'b0;
    logic [1:0] m_q;

    shift_sequencer_if #(.CNT_W(CNT_W)) bus ();

    shift_sequencer #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External negedge-clocked register driven by the sequencer outputs.
    always @(negedge clk) begin
        case (bus.sel)
            3'b000:  m_q <= 2'b00;
            3'b001:  m_q <= bus.D;
            3'b010:  m_q <= {1'b0, m_q[1]};
            3'b011:  m_q <= {m_q[0], 1'b0};
            3'b100:  m_q <= {m_q[1], m_q[1]};
            3'b101:  m_q <= {bus.inp, m_q[1]};
            default: m_q <= {bus.D[0], bus.D[1]};
        endcase
    end

    task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (sync_en) check_eq("qsync", 8'(bus.q_model), 8'(m_q));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [2:0] sel, input logic [1:0] d,
                             input logic [1:0] q, input logic busy, input logic done);
        check_eq({tag, ".sel"}, 8'(bus.sel), 8'(sel));
        check_eq({tag, ".D"}, 8'(bus.D), 8'(d));
        check_eq({tag, ".q"}, 8'(bus.q_model), 8'(q));
        check_eq({tag, ".busy"}, 8'(bus.busy), 8'(busy));
        check_eq({tag, ".done"}, 8'(bus.done), 8'(done));
    endtask

    task automatic issue(input logic [2:0] op, input logic [CNT_W-1:0] cnt,
                         input logic [1:0] data, input logic sin);
        bus.cmd_op    = op;
        bus.cmd_count = cnt;
        bus.cmd_data  = data;
        bus.cmd_inp   = sin;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'b000;
        bus.cmd_count = '0;
        bus.cmd_data  = 2'b00;
        bus.cmd_inp   = 1'b0;

        tick();
        sync_en = 1'b1;
        check_out("rst", 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);
        check_eq("rst.inp", 8'(bus.inp), 8'h0);
        check_eq("rst.rdy", 8'(bus.cmd_ready), 8'h0);
        rst = 1'b0;
        repeat (3) begin
            tick();
            check_out("idle", 3'b001, 2'b00, 2'b00, 1'b0, 1'b0);
            check_eq("idle.rdy", 8'(bus.cmd_ready), 8'h1);
        end

        // Parallel load of 10, single repetition.
        issue(3'b001, 4'd0, 2'b10, 1'b0);
        check_out("ld.acc", 3'b001, 2'b00, 2'b00, 1'b1, 1'b0);
        check_eq("ld.acc.rdy", 8'(bus.cmd_ready), 8'h0);
        tick();
        check_out("ld.r0", 3'b001, 2'b10, 2'b10, 1'b0, 1'b1);
        tick();
        check_out("ld.hold", 3'b001, 2'b10, 2'b10, 1'b0, 1'b0);
        check_eq("ld.hold.rdy", 8'(bus.cmd_ready), 8'h1);

        // Serial-in of ones, three repetitions; busy for exactly three samples.
        issue(3'b101, 4'd2, 2'b00, 1'b1);
        check_out("si.acc", 3'b001, 2'b10, 2'b10, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("si.r", 3'b101, 2'b00, 2'b11, 1'(i < 2), 1'(i == 2));
            check_eq("si.inp", 8'(bus.inp), 8'h1);
        end
        tick();
        check_out("si.end", 3'b001, 2'b11, 2'b11, 1'b0, 1'b0);

        // Shift left from 01 twice, then duplicate from 10.
        issue(3'b001, 4'd0, 2'b01, 1'b0);
        tick();
        check_out("l01", 3'b001, 2'b01, 2'b01, 1'b0, 1'b1);
        issue(3'b011, 4'd1, 2'b00, 1'b0);
        tick();
        check_out("sl.r0", 3'b011, 2'b00, 2'b10, 1'b1, 1'b0);
        tick();
        check_out("sl.r1", 3'b011, 2'b00, 2'b00, 1'b0, 1'b1);
        issue(3'b001, 4'd0, 2'b10, 1'b0);
        tick();
        check_out("l10", 3'b001, 2'b10, 2'b10, 1'b0, 1'b1);
        issue(3'b100, 4'd0, 2'b00, 1'b0);
        tick();
        check_out("dup", 3'b100, 2'b00, 2'b11, 1'b0, 1'b1);

        // cmd_valid held with a different command during RUN: ignored until ready.
        bus.cmd_op    = 3'b110;
        bus.cmd_count = 4'd3;
        bus.cmd_data  = 2'b01;
        bus.cmd_valid = 1'b1;
        tick();
        check_out("hv.acc", 3'b001, 2'b11, 2'b11, 1'b1, 1'b0);
        bus.cmd_op    = 3'b000;
        bus.cmd_count = 4'd0;
        bus.cmd_data  = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out("hv.r", 3'b110, 2'b01, 2'b10, 1'(i < 3), 1'(i == 3));
            check_eq("hv.rdy", 8'(bus.cmd_ready), 8'(i == 3));
        end
        tick();
        check_out("hv.acc2", 3'b001, 2'b10, 2'b10, 1'b1, 1'b0);
        bus.cmd_valid = 1'b0;
        tick();
        check_out("hv.clr", 3'b000, 2'b00, 2'b00, 1'b0, 1'b1);

        // All-ones count gives 16 repetitions without wrapping.
        issue(3'b101, 4'd15, 2'b00, 1'b1);
        check_eq("full.acc.busy", 8'(bus.busy), 8'h1);
        for (int i = 0; i < 16; i++) begin
            tick();
            check_out("full.r", 3'b101, 2'b00, (i == 0) ? 2'b10 : 2'b11, 1'(i < 15), 1'(i == 15));
        end
        tick();
        check_out("full.end", 3'b001, 2'b11, 2'b11, 1'b0, 1'b0);

        // Reset during a long shift-right run; a pending command must not start.
        issue(3'b001, 4'd0, 2'b10, 1'b0);
        tick();
        issue(3'b010, 4'd15, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("sr.r", 3'b010, 2'b00, (i == 0) ? 2'b01 : 2'b00, 1'b1, 1'b0);
        end
        rst           = 1'b1;
        bus.cmd_op    = 3'b001;
        bus.cmd_count = 4'd0;
        bus.cmd_data  = 2'b11;
        bus.cmd_valid = 1'b1;
        repeat (2) begin
            tick();
            check_out("rr", 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);
            check_eq("rr.rdy", 8'(bus.cmd_ready), 8'h0);
        end
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        repeat (2) begin
            tick();
            check_out("post", 3'b001, 2'b00, 2'b00, 1'b0, 1'b0);
            check_eq("post.rdy", 8'(bus.cmd_ready), 8'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 4, width of the repeat-count field (1..2^CNT_W repetitions).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  command accepted this edge when cmd_valid && cmd_ready.
REQ-006 SHALL have port cmd_op  input  3  operation code, same encoding as the 2-bit multi-function shift register sel.
REQ-007 SHALL have port cmd_count  input  CNT_W  repetitions minus one.
REQ-008 SHALL have port cmd_data  input  2  parallel data for ops 001/110/111.
REQ-009 SHALL have port cmd_inp  input  1  serial-in bit for op 101.
REQ-010 SHALL have port sel  output  3  registered select to shift register.
REQ-011 SHALL have port D  output  2  registered parallel data to shift register.
REQ-012 SHALL have port inp  output  1  registered serial-in to shift register.
REQ-013 SHALL have port q_model  output  2  shadow copy of shift register Q after the pending negedge.
REQ-014 SHALL have port busy  output  1  high in RUN.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the last repetition is issued.

Function
REQ-016 SHALL implement two states, IDLE and RUN; cmd_ready SHALL equal (state==IDLE) && !rst.
REQ-017 SHALL, on the accepting edge, latch op, count, data, inp into internal registers and go to RUN; sel/D/inp at that edge take the IDLE hold value.
REQ-018 SHALL, at every edge in IDLE (including the accepting edge), drive sel=001, D=q_model, inp=0, so the negedge-clocked register reloads its own value (the register has no hold code).
REQ-019 SHALL, at each edge in RUN, drive sel=latched op, D=latched data, inp=latched inp, and decrement the repeat counter.
REQ-020 SHALL, at the RUN edge where the counter equals 0, issue the final repetition, return to IDLE and set done=1 for exactly the following cycle.
REQ-021 SHALL issue exactly count+1 repetitions at edges k+1..k+count+1 for acceptance at edge k; next command acceptable at edge k+count+2.
REQ-022 SHALL update q_model on the same edge that drives sel, per op: 000->00; 001->data; 010->{0,q[1]}; 011->{q[0],0}; 100->{q[1],q[1]}; 101->{inp,q[1]}; 110,111->{data[0],data[1]}; IDLE hold->unchanged.
REQ-023 SHALL ignore cmd_valid while busy; latched command fields SHALL NOT change during RUN.
REQ-024 SHALL treat cmd_count=0 as a single repetition and cmd_count=all-ones as 2^CNT_W repetitions with no counter wrap.
REQ-025 SHALL keep busy == (state==RUN) and done==0 in IDLE except the post-completion cycle.

Reset
REQ-026 SHALL, on any edge with rst=1 (including mid-RUN), set state=IDLE, counter=0, done=0, q_model=00, sel=000, D=00, inp=0, so the register clears at the following negedge.
REQ-027 SHALL ignore cmd_valid on edges where rst=1; no command is accepted and none resumes after reset.
REQ-028 SHALL, on the first edge after rst deasserts, resume IDLE hold output (sel=001, D=00).

Verification
REQ-029 Reset then idle 3 cycles -> sel=000 during reset edge, then sel=001, D=00, q_model=00, cmd_ready=1, busy=0.
REQ-030 Load op=001, count=0, data=10 -> one edge sel=001 D=10, q_model=10, done pulse next cycle, then hold D=10.
REQ-031 From Q=10, op=101, count=2, inp=1 -> q_model 11,11,11; three edges with sel=101; done after third; busy high exactly 3 cycles.
REQ-032 From Q=01, op=011, count=1 -> q_model 10 then 00; op=100 from Q=10, count=0 -> 11.
REQ-033 cmd_valid held high with new command during RUN -> ignored; accepted only when cmd_ready=1; back-to-back commands spaced count+2 edges.
REQ-034 Assert rst during RUN of op=010 count=15 -> next outputs sel=000, q_model=00, busy=0, no done pulse; bench shift-register model Q matches q_model every cycle.
